fifo_access_sched: RTL

//  Round-robin scheduler sharing the single-port 32-bit FIFO datapath between NREQ clients.
//  - Serialises client read/write requests into one fifo_en/fifo_r_w command per cycle.
//  - Tracks occupancy, so it never issues a read when empty or a write when full.
//  - Steers read data back to the issuing client.
//  - Sequences the FIFO's synchronous reset at power-up and on flush.

---
 rtl/fifo_access_sched_pkg.sv | 17 +
 rtl/fifo_access_sched_if.sv | 35 +++
 rtl/fifo_access_sched_rr_arbiter.sv | 26 ++
 rtl/fifo_access_sched.sv | 88 ++++++++
 4 files changed

// File: rtl/fifo_access_sched_pkg.sv
// fifo_sched_pkg: shared types and constants for the FIFO access scheduler.
//   sched_state_e  scheduler FSM states
//   cmd_tag_t      issued-command tag (valid, write, client id) carried towards read return
//   FIFO_RD_LAT    cycles from read grant to rvalid
//   id2oh          client index to one-hot
package fifo_sched_pkg;
   typedef enum logic [1:0] {INIT, RUN, FLUSH} sched_state_e;
   typedef struct packed {
      logic       vld;
      logic       wr;
      logic [2:0] id;
   } cmd_tag_t;
   localparam int FIFO_RD_LAT = 2;
   function automatic logic [7:0] id2oh(input logic [2:0] id);
      return 8'(1) << id;
   endfunction
endpackage

// File: rtl/fifo_access_sched_if.sv
// fifo_access_sched_if: client request/return bus plus FIFO command bus of the scheduler.
//   client side : flush, req, req_wr, req_wdata -> ; <- gnt, rvalid, rdata
//   FIFO side   : fifo_out -> ; <- fifo_rst, fifo_en, fifo_r_w, fifo_in
//   status      : <- count, full, empty
//   master = clients + FIFO environment, slave = scheduler
interface fifo_access_sched_if #(
   parameter int NREQ     = 4,
   parameter int DW       = 32,
   parameter int CAPACITY = 7
);
   localparam int CW = $clog2(CAPACITY + 1);
   logic               flush;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic               fifo_rst;
   logic               fifo_en;
   logic               fifo_r_w;
   logic [DW-1:0]      fifo_in;
   logic [DW-1:0]      fifo_out;
   logic [CW-1:0]      count;
   logic               full;
   logic               empty;
   modport master (
      output flush, req, req_wr, req_wdata, fifo_out,
      input  gnt, rvalid, rdata, fifo_rst, fifo_en, fifo_r_w, fifo_in, count, full, empty
   );
   modport slave (
      input  flush, req, req_wr, req_wdata, fifo_out,
      output gnt, rvalid, rdata, fifo_rst, fifo_en, fifo_r_w, fifo_in, count, full, empty
   );
endinterface

// File: rtl/fifo_access_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick among eligible requesters, starting at i_ptr.
//   i_elig  eligible requesters
//   i_ptr   highest-priority index this cycle
//   o_gnt   one-hot grant (zero when nothing eligible)
//   o_idx   encoded grant index (zero when nothing eligible)
module rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_elig,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx
);
   // Scan from farthest to nearest so the entry closest to i_ptr is written last and wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_elig[(int'(i_ptr) + k) % N]) begin
            o_idx = PW'((int'(i_ptr) + k) % N);
            o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/fifo_access_sched.sv
// fifo_access_sched: round-robin scheduler sharing one single-port FIFO between NREQ clients.
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    slave side of fifo_access_sched_if (client requests/returns, FIFO command, status)
module fifo_access_sched
   import fifo_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DW       = 32,
   parameter int CAPACITY = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_access_sched_if.slave   bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(CAPACITY + 1);

   sched_state_e    r_state, w_next;
   cmd_tag_t        r_tag;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_ptr, w_idx;
   logic [NREQ-1:0] w_elig, w_gnt, r_rvalid;
   logic [DW-1:0]   r_rdata, r_fifo_in;
   logic            w_full, w_empty, w_go, w_clr, w_any, w_rd_ret;

   assign w_full  = r_count == CW'(CAPACITY);
   assign w_empty = r_count == '0;
   assign w_any   = |w_gnt;
   assign w_rd_ret = r_tag.vld && !r_tag.wr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= INIT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = (r_state == RUN && bus.flush) ? FLUSH : RUN;
   end

   // A flush request clears occupancy at its own edge so the FLUSH cycle already reads empty.
   always_comb begin
      w_go         = r_state == RUN && !bus.flush;
      w_clr        = r_state == FLUSH || (r_state == RUN && bus.flush);
      bus.fifo_rst = r_state != RUN;
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) w_elig[i] = w_go && bus.req[i] && (bus.req_wr[i] ? !w_full : !w_empty);
   end

   rr_arbiter #(.N(NREQ)) u_arb (
      .i_elig (w_elig),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx)
   );

   // r_tag is both the issued FIFO command and the first stage of the read-return tag;
   // the FIFO presents read data during the issue cycle, so rdata is captured there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr     <= '0;
         r_count   <= '0;
         r_tag     <= '0;
         r_fifo_in <= '0;
         r_rvalid  <= '0;
         r_rdata   <= '0;
      end else begin
         r_tag <= '{vld: w_any, wr: w_any && bus.req_wr[w_idx], id: 3'(w_idx)};
         if (w_any) r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
         if (w_any && bus.req_wr[w_idx]) r_fifo_in <= bus.req_wdata[w_idx*DW +: DW];
         r_count <= w_clr ? '0 : !w_any ? r_count : bus.req_wr[w_idx] ? r_count + 1'b1 : r_count - 1'b1;
         r_rvalid <= w_rd_ret ? NREQ'(id2oh(r_tag.id)) : '0;
         if (w_rd_ret) r_rdata <= bus.fifo_out;
      end
   end

   assign bus.gnt      = w_gnt;
   assign bus.rvalid   = r_rvalid;
   assign bus.rdata    = r_rdata;
   assign bus.fifo_en  = r_tag.vld;
   assign bus.fifo_r_w = r_tag.wr;
   assign bus.fifo_in  = r_fifo_in;
   assign bus.count    = r_count;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
endmodule
